// File: rtl/ex_ctrl_pkg.sv
// Shared types for the EX-stage hazard/flag controller: branch kinds,
// forwarding selects, controller FSM states and the XZR index.
package ex_ctrl_pkg;

  localparam int ZERO_REG = 31;

  typedef enum logic [1:0] {
    BR_NONE   = 2'b00,
    BR_UNCOND = 2'b01,
    BR_CBZ    = 2'b10,
    BR_LT     = 2'b11
  } br_type_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_LU_STALL = 2'b01,
    ST_BR_FLUSH = 2'b10
  } ctrl_state_e;

endpackage

// File: rtl/fwd_unit.sv
// Forwarding select for one ALU operand; the youngest producer (EX/MEM) wins
// over MEM/WB, and XZR is never forwarded.
module fwd_unit #(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = 31
) (
  input  logic [REG_W-1:0]     i_rs,
  input  logic [REG_W-1:0]     i_rd_mem,
  input  logic                 i_we_mem,
  input  logic [REG_W-1:0]     i_rd_wb,
  input  logic                 i_we_wb,
  output ex_ctrl_pkg::fwd_sel_e o_sel
);
  import ex_ctrl_pkg::fwd_sel_e;
  import ex_ctrl_pkg::FWD_REG;
  import ex_ctrl_pkg::FWD_MEM;
  import ex_ctrl_pkg::FWD_WB;

  localparam logic [REG_W-1:0] W_ZR = REG_W'(ZERO_REG);

  logic w_hit_mem;
  logic w_hit_wb;

  assign w_hit_mem = i_we_mem && (i_rd_mem == i_rs) && (i_rd_mem != W_ZR);
  assign w_hit_wb  = i_we_wb  && (i_rd_wb  == i_rs) && (i_rd_wb  != W_ZR);

  always_comb begin
    o_sel = FWD_REG;
    if (w_hit_mem)     o_sel = FWD_MEM;
    else if (w_hit_wb) o_sel = FWD_WB;
  end

endmodule

// File: rtl/ex_hazard_flag_ctrl.sv
// EX-stage controller: operand forwarding, load-use stall, NZVC flag register,
// branch resolution with a one-cycle flush, and saturating stall/flush counters.
module ex_hazard_flag_ctrl #(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = ex_ctrl_pkg::ZERO_REG,
  parameter int CNT_W    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [REG_W-1:0]         rn_ID,
  input  logic [REG_W-1:0]         rm_ID,
  input  logic                     useRn_ID,
  input  logic                     useRm_ID,
  input  logic [REG_W-1:0]         rn_EX,
  input  logic [REG_W-1:0]         rm_EX,
  input  logic                     valid_EX,
  input  logic [REG_W-1:0]         rd_EX,
  input  logic                     RegWE_EX,
  input  logic                     Mem2Reg_EX,
  input  logic                     setFlag_EX,
  input  logic [1:0]               brType_EX,
  input  logic                     ALU_neg,
  input  logic                     ALUzeroFlag,
  input  logic                     ALU_ov,
  input  logic                     ALU_cout,
  input  logic [REG_W-1:0]         rd_MEM,
  input  logic                     RegWE_MEM,
  input  logic [REG_W-1:0]         rd_WB,
  input  logic                     RegWE_WB,
  output logic [1:0]               fwdA,
  output logic [1:0]               fwdB,
  output logic                     stall,
  output logic                     flush,
  output logic                     br_taken,
  output logic                     negFlag,
  output logic                     zeroFlag,
  output logic                     ovFlag,
  output logic                     carryFlag,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         flush_cnt,
  output ex_ctrl_pkg::ctrl_state_e o_dbg_state
);
  import ex_ctrl_pkg::ctrl_state_e;
  import ex_ctrl_pkg::ST_RUN;
  import ex_ctrl_pkg::ST_LU_STALL;
  import ex_ctrl_pkg::ST_BR_FLUSH;
  import ex_ctrl_pkg::br_type_e;
  import ex_ctrl_pkg::BR_NONE;
  import ex_ctrl_pkg::BR_UNCOND;
  import ex_ctrl_pkg::BR_CBZ;
  import ex_ctrl_pkg::BR_LT;
  import ex_ctrl_pkg::fwd_sel_e;

  localparam logic [REG_W-1:0] W_ZR      = REG_W'(ZERO_REG);
  localparam logic [CNT_W-1:0] W_CNT_MAX = {CNT_W{1'b1}};

  ctrl_state_e      r_state;
  ctrl_state_e      w_next;
  logic [3:0]       r_nzvc;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  fwd_sel_e         w_fwd_a;
  fwd_sel_e         w_fwd_b;
  logic             w_lu;
  logic             w_br;
  logic             w_stall;
  logic             w_flush;
  logic             w_unused_regwe_ex;

  // Load-use detection does not need the EX write enable: a load always writes.
  assign w_unused_regwe_ex = RegWE_EX;

  fwd_unit #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_fwd_a (
    .i_rs(rn_EX), .i_rd_mem(rd_MEM), .i_we_mem(RegWE_MEM),
    .i_rd_wb(rd_WB), .i_we_wb(RegWE_WB), .o_sel(w_fwd_a)
  );

  fwd_unit #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_fwd_b (
    .i_rs(rm_EX), .i_rd_mem(rd_MEM), .i_we_mem(RegWE_MEM),
    .i_rd_wb(rd_WB), .i_we_wb(RegWE_WB), .o_sel(w_fwd_b)
  );

  assign w_lu = valid_EX && Mem2Reg_EX && (rd_EX != W_ZR) &&
                ((useRn_ID && (rn_ID == rd_EX)) || (useRm_ID && (rm_ID == rd_EX)));

  // B.LT reads the registered flags: any flag-setter is at least one cycle older.
  always_comb begin
    w_br = 1'b0;
    case (br_type_e'(brType_EX))
      BR_UNCOND: w_br = valid_EX;
      BR_CBZ:    w_br = valid_EX && ALUzeroFlag;
      BR_LT:     w_br = valid_EX && (r_nzvc[3] ^ r_nzvc[1]);
      BR_NONE:   w_br = 1'b0;
      default:   w_br = 1'b0;
    endcase
  end

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_flush = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_br) begin
          w_flush = 1'b1;
          w_next  = ST_BR_FLUSH;
        end else if (w_lu) begin
          w_stall = 1'b1;
          w_next  = ST_LU_STALL;
        end
      end
      ST_LU_STALL: begin
        w_flush = w_br;
        w_next  = w_br ? ST_BR_FLUSH : ST_RUN;
      end
      ST_BR_FLUSH: w_next = ST_RUN;
      default:     w_next = ST_RUN;
    endcase
    if (!reset) begin
      w_stall = 1'b0;
      w_flush = 1'b0;
      w_next  = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_RUN;
      r_nzvc      <= 4'b0000;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (valid_EX && setFlag_EX) r_nzvc <= {ALU_neg, ALUzeroFlag, ALU_ov, ALU_cout};
      if (w_stall && (r_stall_cnt != W_CNT_MAX)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush && (r_flush_cnt != W_CNT_MAX)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign fwdA        = reset ? w_fwd_a : 2'b00;
  assign fwdB        = reset ? w_fwd_b : 2'b00;
  assign stall       = w_stall;
  assign flush       = w_flush;
  assign br_taken    = reset && w_br;
  assign negFlag     = r_nzvc[3];
  assign zeroFlag    = r_nzvc[2];
  assign ovFlag      = r_nzvc[1];
  assign carryFlag   = r_nzvc[0];
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ex_hazard_flag_ctrl.sv
// Bench for ex_hazard_flag_ctrl: directed pipeline scenarios then random traffic,
// all checked against a rule-level reference model of the controller.
module tb_ex_hazard_flag_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [REG_W-1:0] rn_ID, rm_ID, rn_EX, rm_EX, rd_EX, rd_MEM, rd_WB;
  logic useRn_ID, useRm_ID, valid_EX, RegWE_EX, Mem2Reg_EX, setFlag_EX;
  logic [1:0] brType_EX;
  logic ALU_neg, ALUzeroFlag, ALU_ov, ALU_cout, RegWE_MEM, RegWE_WB;
  logic [1:0] fwdA, fwdB;
  logic stall, flush, br_taken, negFlag, zeroFlag, ovFlag, carryFlag;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  ex_ctrl_pkg::ctrl_state_e dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: what happened last cycle, not an FSM encoding.
  logic [3:0] m_nzvc;
  int         m_scnt, m_fcnt;
  bit         m_prev_stall, m_prev_flush;
  logic [5:0] exp_q[$];
  logic [5:0] e_comb;

  always #5 clk = ~clk;

  ex_hazard_flag_ctrl #(.REG_W(REG_W), .ZERO_REG(31), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .rn_ID(rn_ID), .rm_ID(rm_ID), .useRn_ID(useRn_ID), .useRm_ID(useRm_ID),
    .rn_EX(rn_EX), .rm_EX(rm_EX), .valid_EX(valid_EX), .rd_EX(rd_EX),
    .RegWE_EX(RegWE_EX), .Mem2Reg_EX(Mem2Reg_EX), .setFlag_EX(setFlag_EX),
    .brType_EX(brType_EX), .ALU_neg(ALU_neg), .ALUzeroFlag(ALUzeroFlag),
    .ALU_ov(ALU_ov), .ALU_cout(ALU_cout), .rd_MEM(rd_MEM), .RegWE_MEM(RegWE_MEM),
    .rd_WB(rd_WB), .RegWE_WB(RegWE_WB), .fwdA(fwdA), .fwdB(fwdB),
    .stall(stall), .flush(flush), .br_taken(br_taken),
    .negFlag(negFlag), .zeroFlag(zeroFlag), .ovFlag(ovFlag), .carryFlag(carryFlag),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .o_dbg_state(dbg_state)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_exp(input logic [REG_W-1:0] rs);
    if (RegWE_MEM && rd_MEM == rs && rd_MEM != 31) return 2'b01;
    if (RegWE_WB && rd_WB == rs && rd_WB != 31)    return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit lu_exp();
    return valid_EX && Mem2Reg_EX && rd_EX != 31 &&
           ((useRn_ID && rn_ID == rd_EX) || (useRm_ID && rm_ID == rd_EX));
  endfunction

  function automatic bit br_exp();
    if (!valid_EX) return 0;
    case (brType_EX)
      2'd1:    return 1;
      2'd2:    return ALUzeroFlag;
      2'd3:    return m_nzvc[3] != m_nzvc[1];
      default: return 0;
    endcase
  endfunction

  task automatic idle();
    reset = 1'b1;
    {rn_ID, rm_ID, rn_EX, rm_EX, rd_EX, rd_MEM, rd_WB} = '0;
    {useRn_ID, useRm_ID, valid_EX, RegWE_EX, Mem2Reg_EX, setFlag_EX} = '0;
    brType_EX = 2'b00;
    {ALU_neg, ALUzeroFlag, ALU_ov, ALU_cout, RegWE_MEM, RegWE_WB} = '0;
  endtask

  // Combinational outputs, sampled 1 time unit after inputs change at negedge.
  task automatic settle();
    bit br, st, fl;
    ex_ctrl_pkg::ctrl_state_e es;
    #1;
    br = reset && br_exp();
    fl = reset && !m_prev_flush && br;
    st = reset && !m_prev_flush && !m_prev_stall && lu_exp() && !br;
    e_comb = {st, fl, br, 3'b000};
    check_eq("fwdA", fwdA, reset ? fwd_exp(rn_EX) : 2'b00);
    check_eq("fwdB", fwdB, reset ? fwd_exp(rm_EX) : 2'b00);
    check_eq("stall", stall, st);
    check_eq("flush", flush, fl);
    check_eq("br_taken", br_taken, br);
    if (reset) begin
      es = m_prev_flush ? ex_ctrl_pkg::ST_BR_FLUSH :
           m_prev_stall ? ex_ctrl_pkg::ST_LU_STALL : ex_ctrl_pkg::ST_RUN;
      check_eq("state", dbg_state, es);
    end
  endtask

  // Advance one clock: update the model at posedge, then compare registered outputs.
  task automatic clock();
    bit st, fl;
    st = e_comb[5];
    fl = e_comb[4];
    @(posedge clk);
    if (!reset) begin
      m_nzvc = 4'b0000; m_scnt = 0; m_fcnt = 0;
      m_prev_stall = 0; m_prev_flush = 0;
    end else begin
      if (valid_EX && setFlag_EX) m_nzvc = {ALU_neg, ALUzeroFlag, ALU_ov, ALU_cout};
      if (st && m_scnt < CMAX) m_scnt++;
      if (fl && m_fcnt < CMAX) m_fcnt++;
      m_prev_stall = st;
      m_prev_flush = fl;
    end
    exp_q.push_back({2'b00, m_nzvc});
    #1;
    check_eq("nzvc", {negFlag, zeroFlag, ovFlag, carryFlag}, exp_q.pop_front());
    check_eq("stall_cnt", stall_cnt, m_scnt);
    check_eq("flush_cnt", flush_cnt, m_fcnt);
  endtask

  task automatic do_reset();
    @(negedge clk); idle(); reset = 1'b0; settle(); clock();
    @(negedge clk); idle(); settle(); clock();
  endtask

  function automatic logic [REG_W-1:0] rnd_reg();
    return ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
  endfunction

  initial begin
    m_nzvc = '0; m_scnt = 0; m_fcnt = 0; m_prev_stall = 0; m_prev_flush = 0;
    idle();
    do_reset();

    // ADD X1 then SUB X2,X1,X3: operand A from EX/MEM.
    @(negedge clk); idle(); valid_EX = 1; rn_EX = 1; rm_EX = 3; rd_MEM = 1; RegWE_MEM = 1;
    settle();
    check_eq("t1_fwdA", fwdA, 2'b01);
    check_eq("t1_fwdB", fwdB, 2'b00);
    clock();

    // EX/MEM priority, then MEM/WB, then XZR never forwarded.
    @(negedge clk); idle(); valid_EX = 1; rm_EX = 5; rd_MEM = 5; rd_WB = 5;
    RegWE_MEM = 1; RegWE_WB = 1;
    settle(); check_eq("t2_mem", fwdB, 2'b01); clock();
    @(negedge clk); RegWE_MEM = 0; settle(); check_eq("t2_wb", fwdB, 2'b10); clock();
    @(negedge clk); RegWE_MEM = 1; rm_EX = 31; rd_MEM = 31; rd_WB = 31;
    settle(); check_eq("t2_xzr", fwdB, 2'b00); clock();

    // LDUR X4 in EX, ADD reading X4 in ID: one stall cycle.
    do_reset();
    @(negedge clk); idle(); valid_EX = 1; Mem2Reg_EX = 1; RegWE_EX = 1; rd_EX = 4;
    rn_ID = 4; useRn_ID = 1;
    settle(); check_eq("t3_stall", stall, 1'b1); clock();
    @(negedge clk); valid_EX = 0; settle(); check_eq("t3_stall2", stall, 1'b0); clock();
    @(negedge clk); idle(); valid_EX = 1; settle(); clock();
    check_eq("t3_cnt", stall_cnt, 1);

    // SUBS (N=1,V=0) then B.LT: taken, one flush cycle.
    do_reset();
    @(negedge clk); idle(); valid_EX = 1; setFlag_EX = 1; ALU_neg = 1; settle(); clock();
    check_eq("t4_nflag", negFlag, 1'b1);
    @(negedge clk); idle(); valid_EX = 1; brType_EX = 2'b11;
    settle(); check_eq("t4_br", br_taken, 1'b1); check_eq("t4_flush", flush, 1'b1); clock();
    @(negedge clk); idle(); settle(); check_eq("t4_flush2", flush, 1'b0); clock();
    check_eq("t4_fcnt", flush_cnt, 1);
    // Flag-setting bubble must not touch NZVC; B.LT in a bubble is not taken.
    @(negedge clk); idle(); setFlag_EX = 1; ALUzeroFlag = 1; ALU_ov = 1; ALU_cout = 1;
    settle(); clock();
    check_eq("t4_bubble_flags", {negFlag, zeroFlag, ovFlag, carryFlag}, 4'b1000);
    @(negedge clk); idle(); brType_EX = 2'b11; settle();
    check_eq("t4_bubble_br", br_taken, 1'b0); clock();

    // CBZ taken together with a load-use: branch wins.
    do_reset();
    @(negedge clk); idle(); valid_EX = 1; brType_EX = 2'b10; ALUzeroFlag = 1;
    Mem2Reg_EX = 1; rd_EX = 6; rm_ID = 6; useRm_ID = 1;
    settle(); check_eq("t5_flush", flush, 1'b1); check_eq("t5_stall", stall, 1'b0); clock();
    check_eq("t5_state", dbg_state, ex_ctrl_pkg::ST_BR_FLUSH);

    // Reset asserted while in LU_STALL.
    do_reset();
    @(negedge clk); idle(); valid_EX = 1; setFlag_EX = 1; ALU_cout = 1; settle(); clock();
    @(negedge clk); idle(); valid_EX = 1; Mem2Reg_EX = 1; rd_EX = 2; rn_ID = 2; useRn_ID = 1;
    settle(); clock();
    @(negedge clk); valid_EX = 0; reset = 0; settle();
    check_eq("t6_stall", stall, 1'b0); clock();
    @(negedge clk); idle(); settle(); clock();
    check_eq("t6_state", dbg_state, ex_ctrl_pkg::ST_RUN);
    check_eq("t6_nzvc", {negFlag, zeroFlag, ovFlag, carryFlag}, 4'b0000);
    check_eq("t6_scnt", stall_cnt, 0);

    // Random traffic; EX holds a bubble right after any stall or flush.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset       = ($urandom_range(0, 99) != 0);
      valid_EX    = (m_prev_stall || m_prev_flush) ? 1'b0 : ($urandom_range(0, 3) != 0);
      rn_ID = rnd_reg(); rm_ID = rnd_reg(); rn_EX = rnd_reg(); rm_EX = rnd_reg();
      rd_EX = rnd_reg(); rd_MEM = rnd_reg(); rd_WB = rnd_reg();
      useRn_ID    = 1'($urandom_range(0, 1));
      useRm_ID    = 1'($urandom_range(0, 1));
      Mem2Reg_EX  = 1'($urandom_range(0, 1));
      RegWE_EX    = Mem2Reg_EX | 1'($urandom_range(0, 1));
      RegWE_MEM   = 1'($urandom_range(0, 1));
      RegWE_WB    = 1'($urandom_range(0, 1));
      brType_EX   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      setFlag_EX  = (brType_EX == 2'b00) ? 1'($urandom_range(0, 1)) : 1'b0;
      ALU_neg     = 1'($urandom_range(0, 1));
      ALUzeroFlag = 1'($urandom_range(0, 1));
      ALU_ov      = 1'($urandom_range(0, 1));
      ALU_cout    = 1'($urandom_range(0, 1));
      settle();
      clock();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
